// File: rtl/vec_mem_arbiter.sv
// Arbitrates the single memory port between scalar load/store and vector element fetches.
// Vector bursts are locked until vec_last, MAX_BURST beats, or STALL_MAX idle cycles.
module vec_mem_arbiter #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned SEW       = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned STALL_MAX = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            scl_req,
    input  logic            scl_we,
    input  logic [XLEN-1:0] scl_addr,
    input  logic [XLEN-1:0] scl_wdata,
    output logic            scl_gnt,
    output logic            scl_rvalid,
    output logic [XLEN-1:0] scl_rdata,
    input  logic            vec_req,
    input  logic [XLEN-1:0] vec_addr,
    input  logic            vec_last,
    output logic            vec_gnt,
    output logic            vec_rvalid,
    output logic [SEW-1:0]  vec_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [1:0]      arb_owner
);

    localparam int unsigned BW = $clog2(MAX_BURST) + 1;
    localparam int unsigned SW = $clog2(STALL_MAX) + 1;
    localparam logic [BW-1:0] BeatMax  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BeatOne  = BW'(1);
    localparam logic [SW-1:0] StallLim = SW'(STALL_MAX);
    localparam logic [SW-1:0] StallOne = SW'(1);

    typedef enum logic [0:0] {StIdle, StVec} state_e;

    state_e          state_q, state_d;
    logic            last_vec_q, last_vec_d;
    logic [BW-1:0]   beat_q, beat_d, beat_inc;
    logic [SW-1:0]   stall_q, stall_d, stall_inc;
    logic            resp_scl_q, resp_vec_q;
    logic            scl_win, vec_win, lock_exit;

    assign beat_inc  = beat_q + BeatOne;
    assign stall_inc = stall_q + StallOne;

    always_comb begin
        state_d    = state_q;
        last_vec_d = last_vec_q;
        beat_d     = beat_q;
        stall_d    = stall_q;
        scl_win    = 1'b0;
        vec_win    = 1'b0;
        lock_exit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (scl_req && vec_req) begin
                    scl_win = last_vec_q;
                    vec_win = !last_vec_q;
                end else begin
                    scl_win = scl_req;
                    vec_win = vec_req;
                end
                if (scl_win) begin
                    last_vec_d = 1'b0;
                end
                if (vec_win) begin
                    beat_d  = BeatOne;
                    stall_d = '0;
                    if (vec_last || MAX_BURST == 1) begin
                        last_vec_d = 1'b1;
                    end else begin
                        state_d = StVec;
                    end
                end
            end
            StVec: begin
                // Scalar is locked out for the whole burst.
                vec_win = vec_req;
                if (vec_req) begin
                    beat_d  = beat_inc;
                    stall_d = '0;
                    lock_exit = vec_last || (beat_inc == BeatMax);
                end else begin
                    stall_d   = stall_inc;
                    lock_exit = (stall_inc == StallLim);
                end
            end
            default: state_d = StIdle;
        endcase
        if (lock_exit) begin
            state_d    = StIdle;
            last_vec_d = 1'b1;
            beat_d     = '0;
            stall_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            last_vec_q <= 1'b1;
            beat_q     <= '0;
            stall_q    <= '0;
            resp_scl_q <= 1'b0;
            resp_vec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_vec_q <= last_vec_d;
            beat_q     <= beat_d;
            stall_q    <= stall_d;
            resp_scl_q <= scl_gnt && !scl_we;
            resp_vec_q <= vec_gnt;
        end
    end

    // Grants are combinational, so gate them with reset to keep outputs quiet in reset.
    assign scl_gnt   = n_rst && scl_win;
    assign vec_gnt   = n_rst && vec_win;
    assign arb_owner = {vec_gnt, scl_gnt};

    assign mem_en    = scl_gnt || vec_gnt;
    assign mem_we    = scl_gnt && scl_we;
    assign mem_addr  = scl_gnt ? scl_addr : (vec_gnt ? vec_addr : '0);
    assign mem_wdata = scl_gnt ? scl_wdata : '0;

    assign scl_rvalid = resp_scl_q;
    assign vec_rvalid = resp_vec_q;
    assign scl_rdata  = resp_scl_q ? mem_rdata : '0;
    assign vec_rdata  = resp_vec_q ? mem_rdata[SEW-1:0] : '0;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Directed bench for vec_mem_arbiter: arbitration, locked bursts, stall release, reset.
module tb_vec_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        scl_req, scl_we, scl_gnt, scl_rvalid;
    logic [31:0] scl_addr, scl_wdata, scl_rdata;
    logic        vec_req, vec_last, vec_gnt, vec_rvalid;
    logic [31:0] vec_addr, vec_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  arb_owner;

    int n_tests = 0;
    int n_fail  = 0;

    vec_mem_arbiter #(
        .XLEN(32), .SEW(32), .MAX_BURST(16), .STALL_MAX(4)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .scl_req(scl_req), .scl_we(scl_we), .scl_addr(scl_addr), .scl_wdata(scl_wdata),
        .scl_gnt(scl_gnt), .scl_rvalid(scl_rvalid), .scl_rdata(scl_rdata),
        .vec_req(vec_req), .vec_addr(vec_addr), .vec_last(vec_last),
        .vec_gnt(vec_gnt), .vec_rvalid(vec_rvalid), .vec_rdata(vec_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_owner(arb_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
    endfunction

    // Read data appears the cycle after the strobe; junk otherwise so gating is visible.
    always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'hBAD0BAD0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        scl_req = 0; scl_we = 0; scl_addr = 0; scl_wdata = 0;
        vec_req = 0; vec_addr = 0; vec_last = 0;
    endtask

    task automatic do_reset();
        tick(); n_rst = 0; clear_inputs();
        tick(); n_rst = 1;
    endtask

    task automatic test_reset();
        n_rst = 0; clear_inputs(); scl_req = 1; vec_req = 1; vec_addr = 32'h44;
        tick(); tick(); #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_en, mem_we, scl_rvalid, vec_rvalid, arb_owner} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b%b %b want all zero", scl_gnt, vec_gnt,
                     mem_en, mem_we, scl_rvalid, vec_rvalid, arb_owner);
        end
        n_tests++;
        if ({mem_addr, mem_wdata, scl_rdata, vec_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h want 0", mem_addr, mem_wdata,
                     scl_rdata, vec_rdata);
        end
        tick(); clear_inputs(); n_rst = 1;
    endtask

    task automatic test_scalar_read();
        tick(); scl_req = 1; scl_we = 0; scl_addr = 32'h100; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_en, mem_we, arb_owner, mem_addr} !== {6'b101001, 32'h100}) begin
            n_fail++;
            $display("FAIL scl_read_issue: got gnt=%b/%b en=%b we=%b own=%b addr=%h want 1/0 1 0 01 100",
                     scl_gnt, vec_gnt, mem_en, mem_we, arb_owner, mem_addr);
        end
        tick(); clear_inputs(); #1;
        n_tests++;
        if ({scl_rvalid, scl_rdata, vec_rvalid, scl_gnt} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
            n_fail++;
            $display("FAIL scl_read_resp: got rv=%b rd=%h vrv=%b gnt=%b want 1 deadbeef 0 0",
                     scl_rvalid, scl_rdata, vec_rvalid, scl_gnt);
        end
    endtask

    task automatic test_scalar_write();
        tick(); scl_req = 1; scl_we = 1; scl_addr = 32'h104; scl_wdata = 32'h12345678; #1;
        n_tests++;
        if ({scl_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 32'h104, 32'h12345678}) begin
            n_fail++;
            $display("FAIL scl_write_issue: got gnt=%b en=%b we=%b addr=%h wd=%h want 1 1 1 104 12345678",
                     scl_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick(); clear_inputs(); #1;
        n_tests++;
        if ({scl_rvalid, vec_rvalid, scl_rdata} !== 34'h0) begin
            n_fail++;
            $display("FAIL scl_write_no_resp: got rv=%b vrv=%b rd=%h want 0 0 0",
                     scl_rvalid, vec_rvalid, scl_rdata);
        end
    endtask

    task automatic test_tie_rr();
        do_reset();
        tick(); scl_req = 1; scl_addr = 32'h300; vec_req = 1; vec_addr = 32'h400; vec_last = 1; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_addr} !== {2'b10, 32'h300}) begin
            n_fail++;
            $display("FAIL tie1_scalar: got gnt=%b/%b addr=%h want 1/0 300", scl_gnt, vec_gnt, mem_addr);
        end
        tick(); #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_addr, mem_we, mem_wdata, arb_owner} !== {2'b01, 32'h400, 33'h0, 2'b10}) begin
            n_fail++;
            $display("FAIL tie2_vector: got gnt=%b/%b addr=%h we=%b wd=%h own=%b want 0/1 400 0 0 10",
                     scl_gnt, vec_gnt, mem_addr, mem_we, mem_wdata, arb_owner);
        end
        n_tests++;
        if ({scl_rvalid, scl_rdata} !== {1'b1, 32'hA5A50300}) begin
            n_fail++;
            $display("FAIL tie1_resp: got rv=%b rd=%h want 1 a5a50300", scl_rvalid, scl_rdata);
        end
        tick(); #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, vec_rvalid, vec_rdata, scl_rvalid} !== {3'b101, 32'hA5A50400, 1'b0}) begin
            n_fail++;
            $display("FAIL tie3_scalar: got gnt=%b/%b vrv=%b vrd=%h srv=%b want 1/0 1 a5a50400 0",
                     scl_gnt, vec_gnt, vec_rvalid, vec_rdata, scl_rvalid);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_burst16();
        int bad_gnt = 0;
        int bad_rsp = 0;
        for (int i = 0; i < 16; i++) begin
            tick(); vec_req = 1; vec_addr = 32'h200 + 32'(4 * i); vec_last = (i == 15);
            if (i == 2) begin scl_req = 1; scl_we = 0; scl_addr = 32'h500; end
            #1;
            if ({vec_gnt, scl_gnt, mem_addr} !== {2'b10, 32'h200 + 32'(4 * i)}) bad_gnt++;
            if (i > 0 && {vec_rvalid, vec_rdata} !== {1'b1, mem_val(32'h200 + 32'(4 * (i - 1)))})
                bad_rsp++;
        end
        n_tests++;
        if (bad_gnt != 0) begin
            n_fail++;
            $display("FAIL burst16_grants: got %0d bad beats want 0", bad_gnt);
        end
        n_tests++;
        if (bad_rsp != 0) begin
            n_fail++;
            $display("FAIL burst16_resps: got %0d bad responses want 0", bad_rsp);
        end
        tick(); vec_req = 0; vec_last = 0; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_addr, vec_rvalid, vec_rdata} !== {2'b10, 32'h500, 1'b1, 32'hA5A5023C}) begin
            n_fail++;
            $display("FAIL burst16_release: got gnt=%b/%b addr=%h vrv=%b vrd=%h want 1/0 500 1 a5a5023c",
                     scl_gnt, vec_gnt, mem_addr, vec_rvalid, vec_rdata);
        end
        tick(); clear_inputs(); #1;
        n_tests++;
        if ({scl_rvalid, scl_rdata, vec_rvalid} !== {1'b1, 32'hA5A50500, 1'b0}) begin
            n_fail++;
            $display("FAIL burst16_scl_resp: got rv=%b rd=%h vrv=%b want 1 a5a50500 0",
                     scl_rvalid, scl_rdata, vec_rvalid);
        end
    endtask

    task automatic test_max_burst();
        int bad = 0;
        scl_we = 0; scl_addr = 32'h700;
        for (int b = 1; b <= 16; b++) begin
            tick(); scl_req = 1; vec_req = 1; vec_addr = 32'h600 + 32'(4 * (b - 1)); vec_last = 0; #1;
            if ({vec_gnt, scl_gnt} !== 2'b10) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL max_burst_first16: got %0d bad beats want 0", bad);
        end
        tick(); vec_addr = 32'h640; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_addr} !== {2'b10, 32'h700}) begin
            n_fail++;
            $display("FAIL max_burst_release: got gnt=%b/%b addr=%h want 1/0 700", scl_gnt, vec_gnt, mem_addr);
        end
        bad = 0;
        for (int b = 17; b <= 20; b++) begin
            tick(); scl_req = (b >= 18); vec_addr = 32'h600 + 32'(4 * (b - 1)); vec_last = (b == 20); #1;
            if ({vec_gnt, scl_gnt, mem_addr} !== {2'b10, 32'h600 + 32'(4 * (b - 1))}) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL max_burst_second: got %0d bad beats want 0", bad);
        end
        tick(); vec_req = 0; vec_last = 0; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL max_burst_last_exit: got gnt=%b/%b want 1/0", scl_gnt, vec_gnt);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_stall_and_reset();
        int bad = 0;
        tick(); vec_req = 1; vec_addr = 32'h800; #1;
        tick(); vec_addr = 32'h804; #1;
        n_tests++;
        if (vec_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_setup: got vec_gnt=%b want 1", vec_gnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); vec_req = 0; scl_req = 1; scl_we = 0; scl_addr = 32'h900; #1;
            if ({scl_gnt, vec_gnt, mem_en} !== 3'b000) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_locked: got %0d grants during idle want 0", bad);
        end
        tick(); vec_req = 1; vec_addr = 32'h808; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_addr} !== {2'b10, 32'h900}) begin
            n_fail++;
            $display("FAIL stall_release: got gnt=%b/%b addr=%h want 1/0 900", scl_gnt, vec_gnt, mem_addr);
        end
        tick(); scl_req = 0; #1;
        tick(); vec_addr = 32'h80C; #1;
        n_tests++;
        if ({vec_gnt, vec_rvalid, vec_rdata} !== {2'b11, 32'hA5A50808}) begin
            n_fail++;
            $display("FAIL midburst_beat: got gnt=%b vrv=%b vrd=%h want 1 1 a5a50808",
                     vec_gnt, vec_rvalid, vec_rdata);
        end
        n_rst = 0; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_en, scl_rvalid, vec_rvalid, arb_owner, mem_addr, vec_rdata} !== 71'h0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b/%b en=%b rv=%b/%b own=%b addr=%h vrd=%h want all 0",
                     scl_gnt, vec_gnt, mem_en, scl_rvalid, vec_rvalid, arb_owner, mem_addr, vec_rdata);
        end
        tick(); n_rst = 1; scl_req = 1; scl_addr = 32'hA00; vec_req = 1; vec_addr = 32'h810; #1;
        n_tests++;
        if ({scl_gnt, vec_gnt, mem_addr} !== {2'b10, 32'hA00}) begin
            n_fail++;
            $display("FAIL post_reset_tie: got gnt=%b/%b addr=%h want 1/0 a00", scl_gnt, vec_gnt, mem_addr);
        end
        tick(); clear_inputs(); #1;
        n_tests++;
        if ({scl_rvalid, scl_rdata} !== {1'b1, 32'hA5A50A00}) begin
            n_fail++;
            $display("FAIL post_reset_resp: got rv=%b rd=%h want 1 a5a50a00", scl_rvalid, scl_rdata);
        end
    endtask

    initial begin
        clear_inputs();
        n_rst = 0;
        test_reset();
        test_scalar_read();
        test_scalar_write();
        test_tie_rr();
        test_burst16();
        test_max_burst();
        test_stall_and_reset();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
